// File: rtl/mdu_seq_pkg.sv
// Shared core definitions: ALU/MDU op-code space, MDU FSM states and op decode.
// Divide support is compiled in only when MDU_DIV_EN is defined; XLEN is a global macro.
`ifndef XLEN
`define XLEN 32
`endif

package mdu_seq_pkg;

    localparam int XLEN  = `XLEN;
    localparam int CNT_W = $clog2(XLEN);

    typedef logic [7:0] op_t;

    // ALU_* codes occupy 0x00-0x1F; MDU_* codes start at 0x20 so the two never overlap.
    localparam op_t ALU_OP_LAST = 8'h1F;
    localparam op_t MDU_MUL     = 8'h20;
    localparam op_t MDU_MULH    = 8'h21;
    localparam op_t MDU_MULHSU  = 8'h22;
    localparam op_t MDU_MULHU   = 8'h23;
    localparam op_t MDU_DIV     = 8'h24;
    localparam op_t MDU_DIVU    = 8'h25;
    localparam op_t MDU_REM     = 8'h26;
    localparam op_t MDU_REMU    = 8'h27;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    typedef struct packed {
        logic ok;    // op belongs to this unit and is built in
        logic hi;    // return upper product half
        logic sa;    // a is signed
        logic sb;    // b is signed
`ifdef MDU_DIV_EN
        logic div;
        logic rem;
`endif
    } dec_t;

    function automatic dec_t mdu_decode(input op_t op);
        dec_t d;
        d = '0;
        case (op)
            MDU_MUL:    d.ok = 1'b1;
            MDU_MULH:   begin d.ok = 1'b1; d.hi = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            MDU_MULHSU: begin d.ok = 1'b1; d.hi = 1'b1; d.sa = 1'b1; end
            MDU_MULHU:  begin d.ok = 1'b1; d.hi = 1'b1; end
`ifdef MDU_DIV_EN
            MDU_DIV:    begin d.ok = 1'b1; d.div = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            MDU_DIVU:   begin d.ok = 1'b1; d.div = 1'b1; end
            MDU_REM:    begin d.ok = 1'b1; d.div = 1'b1; d.rem = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            MDU_REMU:   begin d.ok = 1'b1; d.div = 1'b1; d.rem = 1'b1; end
`endif
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One-bit iteration step: shift-add multiply, and restoring divide when MDU_DIV_EN is defined.
// hi:lo is the double-width product/remainder:quotient register pair, m the magnitude operand.
module mdu_iter
    import mdu_seq_pkg::*;
(
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
`ifdef MDU_DIV_EN
    input  logic            div,
`endif
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
`ifdef MDU_DIV_EN
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
`endif

    // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        // Multiplier bits are consumed from lo[0]; product bits shift into lo from the top.
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        hi_nxt = sum[XLEN:1];
        lo_nxt = {sum[0], lo[XLEN-1:1]};
`ifdef MDU_DIV_EN
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted[XLEN-1:0] - m;
        if (div) begin
            if (shifted >= {1'b0, m}) begin
                hi_nxt = diff;
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit (RISC-V M): IDLE/CALC FSM, operand capture and sign handling.
// Divide ops exist only when MDU_DIV_EN is defined; otherwise they behave as unsupported ops.
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] r,
    output logic            bsy
);

    state_t           state, state_nxt;
    dec_t             dec;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hi, lo, m, hi_nxt, lo_nxt;
    logic [XLEN-1:0]  abs_a, abs_b, res;
    logic [2*XLEN-1:0] prod;
    logic             a_neg_in, b_neg_in, a_neg, b_neg, hi_sel, last;
`ifdef MDU_DIV_EN
    logic             div_sel, rem_sel;
`endif

    assign dec      = mdu_decode(op);
    assign a_neg_in = dec.sa & a[XLEN-1];
    assign b_neg_in = dec.sb & b[XLEN-1];
    assign abs_a    = a_neg_in ? (~a + 1'b1) : a;
    assign abs_b    = b_neg_in ? (~b + 1'b1) : b;
    assign last     = (cnt == CNT_W'(XLEN - 1));
    assign bsy      = req | (state == ST_CALC);

    mdu_iter u_iter (
        .hi     (hi),
        .lo     (lo),
        .m      (m),
`ifdef MDU_DIV_EN
        .div    (div_sel),
`endif
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req && dec.ok) state_nxt = ST_CALC;
            ST_CALC: if (last)          state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction is applied to the step output so the last CALC cycle can load r directly.
    always_comb begin
        prod = {hi_nxt, lo_nxt};
        if (a_neg ^ b_neg) prod = ~prod + 1'b1;
        res = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (div_sel) begin
            // A zero divisor yields all-ones quotient bits and |a| as remainder; only the
            // quotient sign fix must be skipped. MIN/-1 falls out of the magnitude path.
            if (rem_sel)        res = a_neg ? (~hi_nxt + 1'b1) : hi_nxt;
            else if (m == '0)   res = '1;
            else                res = (a_neg ^ b_neg) ? (~lo_nxt + 1'b1) : lo_nxt;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            hi_sel <= 1'b0;
`ifdef MDU_DIV_EN
            div_sel <= 1'b0;
            rem_sel <= 1'b0;
`endif
            r      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                if (req && dec.ok) begin
                    cnt    <= '0;
                    hi     <= '0;
                    lo     <= abs_b;
                    m      <= abs_a;
                    a_neg  <= a_neg_in;
                    b_neg  <= b_neg_in;
                    hi_sel <= dec.hi;
`ifdef MDU_DIV_EN
                    div_sel <= dec.div;
                    rem_sel <= dec.rem;
                    if (dec.div) begin
                        lo <= abs_a;
                        m  <= abs_b;
                    end
`endif
                end else if (req) begin
                    r <= '0;
                end
            end else begin
                hi  <= hi_nxt;
                lo  <= lo_nxt;
                cnt <= cnt + 1'b1;
                if (last) r <= res;
            end
        end
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter-free width `XLEN` (global macro), default per core build, meaning datapath width.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  1  one-cycle start strobe from core execute stage.
REQ-005 SHALL have port op  input  8  operation code (MDU_* codes, shared with ALU op space).
REQ-006 SHALL have ports a, b  input  XLEN  operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-007 SHALL have port r  output  XLEN  registered result.
REQ-008 SHALL have port bsy  output  1  stall to core, same semantics as ALU bsy.

Function
REQ-009 SHALL support MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with RISC-V M semantics.
REQ-010 SHALL use FSM states IDLE, CALC; IDLE->CALC on req with supported op; CALC->IDLE after XLEN iterations.
REQ-011 SHALL capture op, a, b, sign flags on the req cycle; later input changes ignored.
REQ-012 SHALL drive bsy = req | (state==CALC), combinationally, so the core stalls in the issue cycle.
REQ-013 SHALL iterate one bit per cycle: shift-add multiply (2*XLEN product), restoring divide on magnitudes.
REQ-014 SHALL latch result (sign-corrected) into r at end of the last CALC cycle; latency req-cycle + XLEN; r valid in first cycle bsy=0; r held until next accepted req.
REQ-015 SHALL ignore req while in CALC (no restart, no operand capture).
REQ-016 SHALL treat req as one-cycle; core deasserts req the cycle after issue.
REQ-017 SHALL, for unsupported op on req, stay IDLE, assert bsy for the req cycle only, load r=0 next cycle.
REQ-018 SHALL on divide by zero yield quotient all-ones and remainder = a (signed and unsigned).
REQ-019 SHALL on signed overflow (a = most-negative, b = -1) yield quotient = a, remainder = 0.
REQ-020 SHALL take full XLEN+1-cycle latency for all supported ops, including special cases.

Reset
REQ-021 SHALL on rst force state IDLE, r = 0, internal accumulators = 0; bsy = req while rst is low again.
REQ-022 SHALL abort any in-flight operation on rst, discarding partial results; no output glitch beyond async clear.

Configuration
REQ-023 SHALL compile divider (DIV, DIVU, REM, REMU, REQ-018/019 logic) only when MDU_DIV_EN is defined.
REQ-024 SHALL without MDU_DIV_EN treat divide ops as unsupported per REQ-017; multiply ops unaffected.

Structure
REQ-025 SHALL place MDU_* op codes and FSM state encoding in the shared core.vh package alongside ALU_* codes; codes disjoint from ALU_*.
REQ-026 SHALL keep the iteration datapath in one natural sub-module, mdu_iter (shift/add/subtract step), with FSM and sign handling in mdu_seq.

Verification
REQ-027 SHALL check (XLEN=32) MUL a=7 b=6 req at cycle 0 -> bsy=1 cycles 0..32, bsy=0 cycle 33 with r=42.
REQ-028 SHALL check MULH a=0x80000000 b=0x80000000 -> r=0x40000000; MULHSU a=0xFFFFFFFF b=2 -> r=0xFFFFFFFF.
REQ-029 SHALL check DIV a=-7 b=2 -> r=0xFFFFFFFD; REM same operands -> r=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> r=0x80000000, REM -> 0.
REQ-030 SHALL check DIVU a=0x1234 b=0 -> r=0xFFFFFFFF; REMU same -> r=0x1234; without MDU_DIV_EN DIVU -> bsy one cycle, r=0.
REQ-031 SHALL check rst asserted at CALC cycle 10 -> bsy=0 and r=0 immediately; subsequent MUL 3*5 -> r=15 at normal latency.
REQ-032 SHALL check second req at cycle 5 of a MUL (different a/b) -> ignored; first result delivered at cycle 33 unchanged.
